alu32_rr_arbiter: RTL and testbench



---
 rtl/alu32_rr_arbiter_if.sv | 35 +++
 rtl/alu32_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_alu32_rr_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu32_rr_arbiter_if.sv
// rtl/alu32_rr_arbiter_if.sv - request/response bundle for the shared 32-bit add/sub arbiter
interface alu32_rr_arbiter_if;
  // client request side
  logic        req0;
  logic        req1;
  logic        sub0;
  logic        sub1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        gnt0;
  logic        gnt1;

  // response slot side
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] result;
  logic        carry;
  logic        zero;
  logic        overflow;

  // the arbiter itself
  modport slave (
    input  req0, req1, sub0, sub1, a0, b0, a1, b1, resp_ready,
    output gnt0, gnt1, resp_valid, resp_id, result, carry, zero, overflow
  );

  // clients plus response consumer
  modport master (
    output req0, req1, sub0, sub1, a0, b0, a1, b1, resp_ready,
    input  gnt0, gnt1, resp_valid, resp_id, result, carry, zero, overflow
  );
endinterface

// File: rtl/alu32_rr_arbiter.sv
// rtl/alu32_rr_arbiter.sv - two-client round-robin arbiter sharing one 32-bit add/sub unit
module alu32_rr_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  alu32_rr_arbiter_if.slave   bus
);

  // arbitration history: ID of the most recently granted client
  logic        last_q;

  // response slot
  logic        resp_valid_q;
  logic        resp_id_q;
  logic [31:0] result_q;
  logic        carry_q;
  logic        zero_q;
  logic        overflow_q;

  // grant path
  logic        can_issue;
  logic        gnt0_c;
  logic        gnt1_c;
  logic        any_gnt;
  logic        sel_id;

  // shared datapath
  logic        sel_sub;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] t_op;
  logic [31:0] sum_res;
  logic        sum_carry;
  logic        sum_ovf;
  logic        sum_zero;

  // a new result may issue when the slot is empty or is draining this cycle
  always_comb begin
    can_issue = !resp_valid_q || bus.resp_ready;
  end

  // round-robin grant: a lone requester wins, contention goes to the client not granted last
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n && can_issue) begin
      if (bus.req0 && bus.req1) begin
        if (last_q) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end else begin
        gnt0_c = bus.req0;
        gnt1_c = bus.req1;
      end
    end
  end

  assign any_gnt = gnt0_c | gnt1_c;
  assign sel_id  = gnt1_c;

  // steer the granted client's operands into the shared adder
  always_comb begin
    if (sel_id) begin
      sel_sub = bus.sub1;
      sel_a   = bus.a1;
      sel_b   = bus.b1;
    end else begin
      sel_sub = bus.sub0;
      sel_a   = bus.a0;
      sel_b   = bus.b0;
    end
  end

  // subtract is a + (~b + 1); the +1 is folded into t so carry is a plain adder carry-out
  always_comb begin
    t_op                 = ({32{sel_sub}} ^ sel_b) + {31'd0, sel_sub};
    {sum_carry, sum_res} = {1'b0, sel_a} + {1'b0, t_op};
    sum_ovf              = (sel_a[31] == t_op[31]) && (sum_res[31] != sel_a[31]);
    sum_zero             = (sum_res == 32'd0);
  end

  // remember who was served so the other client wins the next contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (any_gnt) begin
      last_q <= sel_id;
    end
  end

  // slot occupancy: fill on grant, empty on a drain with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
    end else if (any_gnt) begin
      resp_valid_q <= 1'b1;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  // slot payload: loaded only on grant, otherwise held so stalled outputs stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id_q  <= 1'b0;
      result_q   <= 32'd0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (any_gnt) begin
      resp_id_q  <= sel_id;
      result_q   <= sum_res;
      carry_q    <= sum_carry;
      zero_q     <= sum_zero;
      overflow_q <= sum_ovf;
    end
  end

  assign bus.gnt0       = gnt0_c;
  assign bus.gnt1       = gnt1_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.result     = result_q;
  assign bus.carry      = carry_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_alu32_rr_arbiter.sv
// tb/tb_alu32_rr_arbiter.sv - randomized self-checking bench for alu32_rr_arbiter
module tb_alu32_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu32_rr_arbiter_if bus ();

  alu32_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: who was served last and what the response slot holds
  bit          m_last;
  bit          m_valid;
  bit          m_id;
  logic [31:0] m_res;
  bit          m_c;
  bit          m_z;
  bit          m_v;
  bit          e_g0;
  bit          e_g1;

  logic [36:0] dut_resp;
  assign dut_resp = {bus.resp_valid, bus.resp_id, bus.result, bus.carry, bus.zero, bus.overflow};

  function automatic logic [36:0] exp_resp();
    return {m_valid, m_id, m_res, m_c, m_z, m_v};
  endfunction

  // arithmetic from first principles: unsigned 33-bit sum for carry, signed range test for overflow
  function automatic void ref_alu(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit c, output bit z, output bit v);
    logic [31:0]     t;
    longint unsigned u;
    longint          sg;
    t  = s ? (32'd0 - b) : b;
    u  = longint'({32'd0, a}) + longint'({32'd0, t});
    c  = u[32];
    r  = u[31:0];
    sg = longint'($signed(a)) + longint'($signed(t));
    v  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    z  = (r == 32'd0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_last  = 1'b1;
    m_valid = 1'b0;
    m_id    = 1'b0;
    m_res   = 32'd0;
    m_c     = 1'b0;
    m_z     = 1'b0;
    m_v     = 1'b0;
  endtask

  // who should be granted now: nobody if the slot is blocked, else the sole requester, else the one not served last
  task automatic predict();
    bit slot_free;
    slot_free = !m_valid || bus.resp_ready;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (rst_n && slot_free) begin
      if (bus.req0 && bus.req1) begin
        e_g0 = (m_last == 1'b1);
        e_g1 = (m_last == 1'b0);
      end else begin
        e_g0 = bus.req0;
        e_g1 = bus.req1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (e_g0 || e_g1) begin
        m_id    = e_g1;
        m_last  = e_g1;
        m_valid = 1'b1;
        if (e_g1) ref_alu(bus.sub1, bus.a1, bus.b1, m_res, m_c, m_z, m_v);
        else      ref_alu(bus.sub0, bus.a0, bus.b0, m_res, m_c, m_z, m_v);
      end else if (bus.resp_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req0       = 1'b1;
    bus.req1       = 1'b1;
    bus.sub0       = 1'b0;
    bus.sub1       = 1'b1;
    bus.a0         = 32'd10;
    bus.b0         = 32'd20;
    bus.a1         = 32'd30;
    bus.b1         = 32'd5;
    bus.resp_ready = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if ({dut_resp, bus.gnt0, bus.gnt1} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {dut_resp, bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    predict();
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_gnt: got %b want 10", {bus.gnt0, bus.gnt1});
    end
    advance();
    n_checks++;
    if (dut_resp !== exp_resp() || bus.resp_id !== 1'b0 || bus.result !== 32'd30) begin
      n_fail++;
      $display("FAIL reset_first_resp: got %h want %h", dut_resp, exp_resp());
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [5] = '{32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd3};
    logic [31:0] vb [5] = '{32'd3, 32'd1, 32'd1, 32'd0, 32'd3};
    bit          vs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [34:0] vx [5] = '{{32'd2, 3'b100}, {32'h8000_0000, 3'b001}, {32'd0, 3'b110},
                            {32'd0, 3'b010}, {32'd0, 3'b110}};
    bus.req1       = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0 = 1'b1;
      bus.sub0 = vs[i];
      bus.a0   = va[i];
      bus.b0   = vb[i];
      #1;
      predict();
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== {e_g0, e_g1} || bus.gnt0 !== 1'b1) begin
        n_fail++;
        $display("FAIL arith_gnt[%0d]: got %b want 10", i, {bus.gnt0, bus.gnt1});
      end
      advance();
      n_checks++;
      if ({bus.result, bus.carry, bus.zero, bus.overflow} !== vx[i] || bus.resp_valid !== 1'b1 ||
          dut_resp !== exp_resp()) begin
        n_fail++;
        $display("FAIL arith_vec[%0d]: got %h want %h", i,
                 {bus.resp_valid, bus.result, bus.carry, bus.zero, bus.overflow}, {1'b1, vx[i]});
      end
    end
    bus.req0 = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req0       = 1'b1;
    bus.req1       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.sub0 = $urandom;
      bus.sub1 = $urandom;
      bus.a0   = pick();
      bus.b0   = pick();
      bus.a1   = pick();
      bus.b1   = pick();
      #1;
      predict();
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== {e_g0, e_g1}) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", i, {bus.gnt0, bus.gnt1}, {e_g0, e_g1});
      end
      advance();
      n_checks++;
      if (bus.resp_id !== 1'(i % 2) || bus.resp_valid !== 1'b1 || dut_resp !== exp_resp()) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: got %h want %h (id %0d)", i, dut_resp, exp_resp(), i % 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] held;
    held           = exp_resp();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      predict();
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_gnt[%0d]: got %b want 00", i, {bus.gnt0, bus.gnt1});
      end
      advance();
      n_checks++;
      if (dut_resp !== held || dut_resp !== exp_resp()) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h want %h", i, dut_resp, held);
      end
    end
    bus.resp_ready = 1'b1;
    #1;
    predict();
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release_gnt: got %b want 10", {bus.gnt0, bus.gnt1});
    end
    advance();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || dut_resp !== exp_resp()) begin
      n_fail++;
      $display("FAIL bp_release_resp: got %h want %h", dut_resp, exp_resp());
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req1       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.req0 = 1'b1;
      bus.sub0 = $urandom;
      bus.sub1 = $urandom;
      bus.a0   = pick();
      bus.b0   = pick();
      bus.a1   = pick();
      bus.b1   = pick();
      #1;
      predict();
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== ((i == 4) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL single_gnt[%0d]: got %b want %b", i, {bus.gnt0, bus.gnt1}, (i == 4) ? 2'b10 : 2'b01);
      end
      advance();
      n_checks++;
      if (bus.resp_id !== ((i == 4) ? 1'b0 : 1'b1) || dut_resp !== exp_resp()) begin
        n_fail++;
        $display("FAIL single_resp[%0d]: got %h want %h", i, dut_resp, exp_resp());
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 1'b1;
    bus.req0       = 1'b1;
    bus.sub0       = 1'b0;
    bus.a0         = 32'h1234_5678;
    bus.b0         = 32'h1111_1111;
    #1;
    predict();
    advance();
    bus.req0       = 1'b0;
    bus.req1       = 1'b1;
    bus.sub1       = 1'b1;
    bus.a1         = 32'd100;
    bus.b1         = 32'd1;
    bus.resp_ready = 1'b0;
    #1;
    predict();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || {bus.gnt0, bus.gnt1} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_stall: got valid %b gnt %b want valid 1 gnt 00", bus.resp_valid, {bus.gnt0, bus.gnt1});
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({dut_resp, bus.gnt0, bus.gnt1} !== 39'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h want 0", {dut_resp, bus.gnt0, bus.gnt1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    predict();
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_first_gnt: got %b want 01", {bus.gnt0, bus.gnt1});
    end
    advance();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.result !== 32'd99 || dut_resp !== exp_resp()) begin
      n_fail++;
      $display("FAIL mid_first_resp: got %h want %h", dut_resp, exp_resp());
    end
    bus.req1 = 1'b0;
  endtask

  task automatic test_random();
    bit g0;
    bit g1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0) begin
        bus.req0 = ($urandom_range(0, 2) != 0);
        bus.sub0 = $urandom;
        bus.a0   = pick();
        bus.b0   = pick();
      end
      if (!bus.req1) begin
        bus.req1 = ($urandom_range(0, 2) != 0);
        bus.sub1 = $urandom;
        bus.a1   = pick();
        bus.b1   = pick();
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      g0 = e_g0;
      g1 = e_g1;
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== {e_g0, e_g1}) begin
        n_fail++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", i, {bus.gnt0, bus.gnt1}, {e_g0, e_g1});
      end
      advance();
      n_checks++;
      if (dut_resp !== exp_resp()) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: got %h want %h", i, dut_resp, exp_resp());
      end
      if (g0) bus.req0 = 1'b0;
      if (g1) bus.req1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_single();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
